// File: rtl/taillight_pkg.sv
// Shared types and helpers for the sequential taillight controller.
//   side_mode_e      : operating mode of one lamp side
//   PHASE_W          : width of a side's sweep phase register (holds 0..N_LAMPS)
//   derive_side_mode : priority decode of driver controls into one side's mode
package taillight_pkg;

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_TURN,
        MODE_BRAKE,
        MODE_HAZARD
    } side_mode_e;

    // Sized for the largest supported lamp count (8), so any N_LAMPS fits.
    localparam int MAX_LAMPS = 8;
    localparam int PHASE_W   = $clog2(MAX_LAMPS + 1);

    // Pressing both turn stalks at once is treated as a hazard request.
    function automatic side_mode_e derive_side_mode(
        input logic hazard,
        input logic left,
        input logic right,
        input logic own_turn,
        input logic brake
    );
        if (hazard || (left && right)) return MODE_HAZARD;
        if (own_turn)                  return MODE_TURN;
        if (brake)                     return MODE_BRAKE;
        return MODE_OFF;
    endfunction

endpackage

// File: rtl/taillight_seq_ctrl_if.sv
// Driver-control / lamp-drive bundle of the taillight controller.
//   left, right, brake, hazard, runlight : debounced driver controls
//   dim_duty  : running-light duty in 1/2^PWM_BITS units
//   lights    : lamp drives, [N_LAMPS-1:0] left side, upper half right side
//   step_tick : one-cycle pulse per sequence step
// master = control source / lamp-driver side, slave = the controller.
interface taillight_seq_ctrl_if #(
    parameter int N_LAMPS  = 3,
    parameter int PWM_BITS = 4
);
    logic                  left;
    logic                  right;
    logic                  brake;
    logic                  hazard;
    logic                  runlight;
    logic [PWM_BITS-1:0]   dim_duty;
    logic [2*N_LAMPS-1:0]  lights;
    logic                  step_tick;

    modport master (
        output left, right, brake, hazard, runlight, dim_duty,
        input  lights, step_tick
    );

    modport slave (
        input  left, right, brake, hazard, runlight, dim_duty,
        output lights, step_tick
    );
endinterface

// File: rtl/taillight_pwm_dimmer.sv
// Free-running PWM generator for running-light dimming.
//   clk, rst_n : system clock, async active-low reset
//   dim_duty   : on-time in counts of a 2^PWM_BITS period
//   pwm_on     : high while the counter is below dim_duty
module taillight_pwm_dimmer #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] dim_duty,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] pwm_cnt;

    // Natural wrap at 2^PWM_BITS; max duty therefore leaves one dark count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    assign pwm_on = (pwm_cnt < dim_duty);

endmodule

// File: rtl/taillight_seq_ctrl.sv
// Sequential taillight controller: turn sweep, brake, hazard and dimmed
// running lights for N_LAMPS lamps per side.
//   clk, rst_n : system clock, async active-low reset
//   bus        : driver controls in, lamp drives and step_tick out
//
// Per-side mode FSM:
//   state       | meaning
//   MODE_OFF    | no request, lamps dark (or dimmed running light)
//   MODE_TURN   | sweep innermost-first, phase 0..N_LAMPS then wrap
//   MODE_BRAKE  | all lamps of the side lit
//   MODE_HAZARD | whole side flashes, phase toggles 0/1 each step
module taillight_seq_ctrl
    import taillight_pkg::*;
#(
    parameter int N_LAMPS  = 3,
    parameter int STEP_DIV = 4,
    parameter int PWM_BITS = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    taillight_seq_ctrl_if.slave  bus
);

    localparam int DIV_W = $clog2(STEP_DIV);

    logic [DIV_W-1:0]     div_cnt;
    logic                 step_tick;
    logic                 pwm_on;
    logic [2*N_LAMPS-1:0] lit_all;
    logic [2*N_LAMPS-1:0] lights_q;

    // Step prescaler, independent of the mode logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                div_cnt <= '0;
        else if (div_cnt == DIV_W'(STEP_DIV - 1))  div_cnt <= '0;
        else                                       div_cnt <= div_cnt + DIV_W'(1);
    end

    assign step_tick = (div_cnt == DIV_W'(STEP_DIV - 1));

    taillight_pwm_dimmer #(
        .PWM_BITS (PWM_BITS)
    ) u_dimmer (
        .clk      (clk),
        .rst_n    (rst_n),
        .dim_duty (bus.dim_duty),
        .pwm_on   (pwm_on)
    );

    // Side 0 = left (lights[N_LAMPS-1:0]), side 1 = right (upper half).
    for (genvar s = 0; s < 2; s++) begin : g_side
        localparam bit IS_LEFT = (s == 0);

        side_mode_e           mode_q, mode_d;
        logic [PHASE_W-1:0]   phase_q, phase_d;
        logic [N_LAMPS-1:0]   side_lit;
        logic                 own_turn;

        assign own_turn = IS_LEFT ? bus.left : bus.right;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q  <= MODE_OFF;
                phase_q <= '0;
            end else begin
                mode_q  <= mode_d;
                phase_q <= phase_d;
            end
        end

        // A mode change restarts the sequence even on a step edge; since the
        // hazard condition is common to both sides they restart together.
        always_comb begin
            mode_d  = derive_side_mode(bus.hazard, bus.left, bus.right,
                                       own_turn, bus.brake);
            phase_d = phase_q;
            if (mode_d != mode_q) begin
                phase_d = '0;
            end else if (step_tick) begin
                case (mode_q)
                    MODE_TURN:   phase_d = (phase_q == PHASE_W'(N_LAMPS)) ?
                                           '0 : phase_q + PHASE_W'(1);
                    MODE_HAZARD: phase_d = (phase_q == '0) ? PHASE_W'(1) : '0;
                    default:     phase_d = '0;
                endcase
            end
        end

        // k counts lamps from the inside out; map to the side's bit order.
        always_comb begin
            side_lit = '0;
            for (int k = 0; k < N_LAMPS; k++) begin
                side_lit[IS_LEFT ? (N_LAMPS - 1 - k) : k] =
                    (mode_q == MODE_BRAKE) ||
                    ((mode_q == MODE_HAZARD) && (phase_q == PHASE_W'(1))) ||
                    ((mode_q == MODE_TURN) && (PHASE_W'(k) < phase_q));
            end
        end

        assign lit_all[s*N_LAMPS +: N_LAMPS] = side_lit;
    end

    // Unlit lamps carry the dim PWM; lit lamps are forced fully on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lights_q <= '0;
        else        lights_q <= lit_all | {(2*N_LAMPS){bus.runlight & pwm_on}};
    end

    assign bus.lights    = lights_q;
    assign bus.step_tick = step_tick;

endmodule
